// File: rtl/reservation_station_pkg.sv
// Shared types for the integer reservation station: opcodes, the entry record
// and the issue-register payload.
package types;

    localparam int RS_DATA_W    = 32;
    localparam int RS_ADDR_W    = 32;
    localparam int RS_TAG_W     = 6;
    localparam int RS_DEPTH_DEF = 4;
    localparam int RS_AGE_W     = $clog2(RS_DEPTH_DEF);

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_AND = 4'd2,
        OP_OR  = 4'd3,
        OP_XOR = 4'd4,
        OP_SLL = 4'd5,
        OP_SRL = 4'd6,
        OP_BEQ = 4'd7,
        OP_BNE = 4'd8
    } opcode_t;

    typedef struct packed {
        logic                             valid;
        opcode_t                          opcode;
        logic [RS_ADDR_W-1:0]             iaddr;
        logic [RS_DATA_W-1:0]             insn;
        logic [1:0]                       rdy;
        logic [1:0][RS_DATA_W-1:0]        data;
        logic [1:0][RS_TAG_W-1:0]         tag;
        logic [RS_TAG_W-1:0]              dst_tag;
        logic [RS_AGE_W-1:0]              age;
    } rs_entry_t;

    typedef struct packed {
        opcode_t              opcode;
        logic [RS_ADDR_W-1:0] iaddr;
        logic [RS_DATA_W-1:0] insn;
        logic [RS_DATA_W-1:0] src_a;
        logic [RS_DATA_W-1:0] src_b;
        logic [RS_TAG_W-1:0]  tag;
    } fu_issue_t;

    // Ages saturate so the oldest entry stays the maximum.
    function automatic logic [RS_AGE_W-1:0] age_inc(input logic [RS_AGE_W-1:0] age);
        return (age == RS_AGE_W'(RS_DEPTH_DEF - 1)) ? age : age + 1'b1;
    endfunction

endpackage

// File: rtl/reservation_station_if.sv
// Dispatch-to-reservation-station channel; stall flows back to dispatch.
interface rs_dispatch_if
    import types::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TAG_WIDTH  = 6
);
    logic                       en;
    logic                       stall;
    opcode_t                    opcode;
    logic [ADDR_WIDTH-1:0]      iaddr;
    logic [DATA_WIDTH-1:0]      insn;
    logic [1:0]                 src_rdy;
    logic [1:0][DATA_WIDTH-1:0] src_data;
    logic [1:0][TAG_WIDTH-1:0]  src_tag;
    logic [TAG_WIDTH-1:0]       dst_tag;

    modport source (
        output en, opcode, iaddr, insn, src_rdy, src_data, src_tag, dst_tag,
        input  stall
    );

    modport sink (
        input  en, opcode, iaddr, insn, src_rdy, src_data, src_tag, dst_tag,
        output stall
    );
endinterface

// File: rtl/reservation_station_age_select.sv
// Oldest-ready picker: one-hot grant on the candidate with the largest age;
// ties resolve to the lowest index.
module rs_age_select #(
    parameter int RS_DEPTH = 4,
    parameter int AGE_W    = $clog2(RS_DEPTH)
) (
    input  logic [RS_DEPTH-1:0]            cand,
    input  logic [RS_DEPTH-1:0][AGE_W-1:0] age,
    output logic [RS_DEPTH-1:0]            grant,
    output logic                           found
);
    logic [AGE_W-1:0] best_age;

    // NOTE: every output of a combinational block gets a default first, so no path leaves it holding state (no latch).
    always_comb begin
        grant    = '0;
        found    = 1'b0;
        best_age = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (cand[i] && (!found || age[i] > best_age)) begin
                grant    = '0;
                grant[i] = 1'b1;
                found    = 1'b1;
                best_age = age[i];
            end
        end
    end
endmodule

// File: rtl/reservation_station.sv
// Integer reservation station: holds dispatched instructions until operands
// arrive from the CDB, then issues the oldest ready one through a register.
module reservation_station
    import types::*;
#(
    parameter int DATA_WIDTH = RS_DATA_W,
    parameter int ADDR_WIDTH = RS_ADDR_W,
    parameter int TAG_WIDTH  = RS_TAG_W,
    parameter int RS_DEPTH   = RS_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    rs_dispatch_if.sink           rs_dispatch,
    input  logic                  cdb_en,
    input  logic [TAG_WIDTH-1:0]  cdb_tag,
    input  logic [DATA_WIDTH-1:0] cdb_data,
    input  logic                  flush,
    input  logic                  fu_rdy,
    output logic                  fu_valid,
    output opcode_t               fu_opcode,
    output logic [ADDR_WIDTH-1:0] fu_iaddr,
    output logic [DATA_WIDTH-1:0] fu_insn,
    output logic [DATA_WIDTH-1:0] fu_src_a,
    output logic [DATA_WIDTH-1:0] fu_src_b,
    output logic [TAG_WIDTH-1:0]  fu_tag
);
    rs_entry_t [RS_DEPTH-1:0]   ent_q, ent_d;
    logic                       fu_valid_q, fu_valid_d;
    fu_issue_t                  fu_q, fu_d;

    logic [RS_DEPTH-1:0]               valid_vec, cand, grant, wr_oh;
    logic [RS_DEPTH-1:0][RS_AGE_W-1:0] age_vec;
    logic                              found, full, wr_found, do_write, issue_en;
    logic [1:0]                        byp_hit;
    rs_entry_t                         new_ent, sel_ent, cur;

    always_comb begin
        valid_vec = '0;
        cand      = '0;
        age_vec   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_vec[i] = ent_q[i].valid;
            cand[i]      = ent_q[i].valid && (&ent_q[i].rdy);
            age_vec[i]   = ent_q[i].age;
        end
    end

    // Stall looks only at registered occupancy, never at this cycle's issue.
    assign full              = &valid_vec;
    assign rs_dispatch.stall = full;
    assign do_write          = rs_dispatch.en && !full;
    assign issue_en          = !fu_valid_q || fu_rdy;

    rs_age_select #(
        .RS_DEPTH (RS_DEPTH),
        .AGE_W    (RS_AGE_W)
    ) u_age_select (
        .cand  (cand),
        .age   (age_vec),
        .grant (grant),
        .found (found)
    );

    always_comb begin
        wr_oh    = '0;
        wr_found = 1'b0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (!ent_q[i].valid && !wr_found) begin
                wr_oh[i] = 1'b1;
                wr_found = 1'b1;
            end
        end
    end

    // Incoming entry, with operands that appear on the CDB this same cycle.
    always_comb begin
        byp_hit         = '0;
        new_ent         = '0;
        new_ent.valid   = 1'b1;
        new_ent.opcode  = rs_dispatch.opcode;
        new_ent.iaddr   = rs_dispatch.iaddr;
        new_ent.insn    = rs_dispatch.insn;
        new_ent.dst_tag = rs_dispatch.dst_tag;
        for (int k = 0; k < 2; k++) begin
            byp_hit[k]      = !rs_dispatch.src_rdy[k] && cdb_en && (cdb_tag == rs_dispatch.src_tag[k]);
            new_ent.rdy[k]  = rs_dispatch.src_rdy[k] || byp_hit[k];
            new_ent.data[k] = byp_hit[k] ? cdb_data : rs_dispatch.src_data[k];
            new_ent.tag[k]  = rs_dispatch.src_tag[k];
        end
    end

    always_comb begin
        ent_d = ent_q;
        cur   = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            cur = ent_q[i];
            for (int k = 0; k < 2; k++) begin
                if (cur.valid && !cur.rdy[k] && cdb_en && (cur.tag[k] == cdb_tag)) begin
                    cur.rdy[k]  = 1'b1;
                    cur.data[k] = cdb_data;
                end
            end
            if (do_write && cur.valid) begin
                cur.age = age_inc(cur.age);
            end
            if (issue_en && grant[i]) begin
                cur.valid = 1'b0;
            end
            if (do_write && wr_oh[i]) begin
                cur = new_ent;
            end
            if (flush) begin
                cur = '0;
            end
            ent_d[i] = cur;
        end
    end

    always_comb begin
        sel_ent = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (grant[i]) begin
                sel_ent = ent_q[i];
            end
        end
    end

    // The issue register only advances when empty or accepted downstream.
    always_comb begin
        fu_valid_d = fu_valid_q;
        fu_d       = fu_q;
        if (issue_en) begin
            fu_valid_d = found;
            if (found) begin
                fu_d.opcode = sel_ent.opcode;
                fu_d.iaddr  = sel_ent.iaddr;
                fu_d.insn   = sel_ent.insn;
                fu_d.src_a  = sel_ent.data[0];
                fu_d.src_b  = sel_ent.data[1];
                fu_d.tag    = sel_ent.dst_tag;
            end
        end
        if (flush) begin
            fu_valid_d = 1'b0;
        end
    end

    // NOTE: the entry array is a handful of flops whose valid bits must start clear, so it is reset like any control register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ent_q      <= '0;
            fu_valid_q <= 1'b0;
            fu_q       <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
            ent_q      <= ent_d;
            fu_valid_q <= fu_valid_d;
            fu_q       <= fu_d;
        end
    end

    assign fu_valid  = fu_valid_q;
    assign fu_opcode = fu_q.opcode;
    assign fu_iaddr  = fu_q.iaddr;
    assign fu_insn   = fu_q.insn;
    assign fu_src_a  = fu_q.src_a;
    assign fu_src_b  = fu_q.src_b;
    assign fu_tag    = fu_q.tag;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: expected issues go into a queue,
// a monitor pops and compares each accepted issue.
module tb_reservation_station;
    import types::*;

    logic        clk;
    logic        rst;
    logic        cdb_en;
    logic [5:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        flush;
    logic        fu_rdy;
    logic        fu_valid;
    opcode_t     fu_opcode;
    logic [31:0] fu_iaddr;
    logic [31:0] fu_insn;
    logic [31:0] fu_src_a;
    logic [31:0] fu_src_b;
    logic [5:0]  fu_tag;

    rs_dispatch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TAG_WIDTH(6)) disp ();

    reservation_station #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TAG_WIDTH  (6),
        .RS_DEPTH   (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rs_dispatch (disp),
        .cdb_en      (cdb_en),
        .cdb_tag     (cdb_tag),
        .cdb_data    (cdb_data),
        .flush       (flush),
        .fu_rdy      (fu_rdy),
        .fu_valid    (fu_valid),
        .fu_opcode   (fu_opcode),
        .fu_iaddr    (fu_iaddr),
        .fu_insn     (fu_insn),
        .fu_src_a    (fu_src_a),
        .fu_src_b    (fu_src_b),
        .fu_tag      (fu_tag)
    );

    typedef struct {
        opcode_t     op;
        logic [31:0] iaddr;
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  tag;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input opcode_t op, input logic [31:0] iaddr, input logic [31:0] insn,
                        input logic [31:0] a, input logic [31:0] b, input logic [5:0] tag);
        exp_t e;
        e.op = op; e.iaddr = iaddr; e.insn = insn; e.a = a; e.b = b; e.tag = tag;
        exp_q.push_back(e);
    endtask

    // rdy[0] is operand A, rdy[1] is operand B.
    task automatic drive_disp(input opcode_t op, input logic [31:0] iaddr, input logic [31:0] insn,
                              input logic [1:0] rdy, input logic [31:0] a, input logic [31:0] b,
                              input logic [5:0] ta, input logic [5:0] tb, input logic [5:0] dst);
        disp.en          = 1'b1;
        disp.opcode      = op;
        disp.iaddr       = iaddr;
        disp.insn        = insn;
        disp.src_rdy     = rdy;
        disp.src_data[0] = a;
        disp.src_data[1] = b;
        disp.src_tag[0]  = ta;
        disp.src_tag[1]  = tb;
        disp.dst_tag     = dst;
    endtask

    task automatic idle_disp();
        disp.en = 1'b0;
    endtask

    task automatic cdb(input logic [5:0] tag, input logic [31:0] data);
        cdb_en   = 1'b1;
        cdb_tag  = tag;
        cdb_data = data;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'(0));
    endtask

    // Monitor: an issue counts when fu_valid and fu_rdy are both high.
    always @(negedge clk) begin
        if (!rst && fu_valid && fu_rdy) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_issue: got tag 0x%0h required no issue", fu_tag);
            end else begin
                mon_e = exp_q.pop_front();
                check("issue_opcode", 64'(fu_opcode), 64'(mon_e.op));
                check("issue_iaddr",  64'(fu_iaddr),  64'(mon_e.iaddr));
                check("issue_insn",   64'(fu_insn),   64'(mon_e.insn));
                check("issue_src_a",  64'(fu_src_a),  64'(mon_e.a));
                check("issue_src_b",  64'(fu_src_b),  64'(mon_e.b));
                check("issue_tag",    64'(fu_tag),    64'(mon_e.tag));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; fu_rdy = 1'b0;
        cdb_en = 1'b0; cdb_tag = '0; cdb_data = '0;
        disp.en = 1'b0; disp.opcode = OP_ADD; disp.iaddr = '0; disp.insn = '0;
        disp.src_rdy = '0; disp.src_data = '0; disp.src_tag = '0; disp.dst_tag = '0;
        repeat (2) @(posedge clk);
        #1;

        check("reset_fu_valid", 64'(fu_valid),    64'(0));
        check("reset_stall",    64'(disp.stall),  64'(0));
        check("reset_fu_src_a", 64'(fu_src_a),    64'(0));
        check("reset_fu_src_b", 64'(fu_src_b),    64'(0));
        check("reset_fu_tag",   64'(fu_tag),      64'(0));
        check("reset_fu_iaddr", 64'(fu_iaddr),    64'(0));
        check("reset_fu_insn",  64'(fu_insn),     64'(0));
        rst = 1'b0;
        tick();

        // Both operands ready at dispatch: issue one edge after the write.
        fu_rdy = 1'b1;
        push(OP_ADD, 32'h100, 32'hAAAA_0001, 32'd5, 32'd7, 6'd3);
        drive_disp(OP_ADD, 32'h100, 32'hAAAA_0001, 2'b11, 32'd5, 32'd7, 6'd0, 6'd0, 6'd3);
        tick();
        idle_disp();
        check("ready_not_yet_issued", 64'(fu_valid), 64'(0));
        tick();
        check("ready_fu_valid", 64'(fu_valid), 64'(1));
        check("ready_src_a",    64'(fu_src_a), 64'(5));
        check("ready_src_b",    64'(fu_src_b), 64'(7));
        check("ready_tag",      64'(fu_tag),   64'(3));
        tick();

        // Operand B arrives on the CDB two cycles after dispatch.
        push(OP_SUB, 32'h104, 32'hBBBB_0002, 32'd1, 32'h42, 6'd5);
        drive_disp(OP_SUB, 32'h104, 32'hBBBB_0002, 2'b01, 32'd1, 32'd0, 6'd0, 6'd9, 6'd5);
        tick();
        idle_disp();
        tick();
        cdb(6'd9, 32'h42);
        check("cdb_wait_fu_valid", 64'(fu_valid), 64'(0));
        tick();
        cdb_en = 1'b0;
        check("cdb_captured_not_issued", 64'(fu_valid), 64'(0));
        tick();
        check("cdb_fu_valid", 64'(fu_valid), 64'(1));
        check("cdb_src_b",    64'(fu_src_b), 64'(32'h42));
        tick();

        // Same-cycle bypass of operand A during dispatch.
        push(OP_AND, 32'h108, 32'hCCCC_0003, 32'h11, 32'h22, 6'd6);
        drive_disp(OP_AND, 32'h108, 32'hCCCC_0003, 2'b10, 32'hDEAD, 32'h22, 6'd4, 6'd0, 6'd6);
        cdb(6'd4, 32'h11);
        tick();
        idle_disp();
        cdb_en = 1'b0;
        tick();
        check("bypass_fu_valid", 64'(fu_valid), 64'(1));
        check("bypass_src_a",    64'(fu_src_a), 64'(32'h11));
        tick();
        drain(5);

        // Fill all four entries with operand B outstanding (tags 16..19).
        fu_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive_disp(OP_OR, 32'h200 + 32'(4 * k), 32'hD000_0000 + 32'(k), 2'b01,
                       32'h100 + 32'(k), 32'd0, 6'd0, 6'(16 + k), 6'(20 + k));
            tick();
        end
        idle_disp();
        check("full_stall",    64'(disp.stall), 64'(1));
        check("full_fu_valid", 64'(fu_valid),   64'(0));
        drive_disp(OP_XOR, 32'h2F0, 32'hEEEE_0000, 2'b11, 32'h55, 32'h66, 6'd0, 6'd0, 6'd30);
        tick();
        idle_disp();
        check("fifth_stall_kept", 64'(disp.stall), 64'(1));
        tick();
        check("fifth_not_issued", 64'(fu_valid), 64'(0));

        // Expected order: 2 (ready first), then 0 (oldest), 3, 1.
        push(OP_OR, 32'h208, 32'hD000_0002, 32'h102, 32'h302, 6'd22);
        push(OP_OR, 32'h200, 32'hD000_0000, 32'h100, 32'h300, 6'd20);
        push(OP_OR, 32'h20C, 32'hD000_0003, 32'h103, 32'h303, 6'd23);
        push(OP_OR, 32'h204, 32'hD000_0001, 32'h101, 32'h301, 6'd21);
        cdb(6'd18, 32'h302);
        tick();
        check("stall_before_leave", 64'(disp.stall), 64'(1));
        cdb(6'd16, 32'h300);
        tick();
        check("first_issue_valid", 64'(fu_valid),   64'(1));
        check("first_issue_tag",   64'(fu_tag),     64'(22));
        check("stall_after_leave", 64'(disp.stall), 64'(0));
        cdb(6'd19, 32'h303);
        tick();
        cdb_en = 1'b0;

        // fu_rdy low: the issue register must hold its contents.
        for (int c = 0; c < 3; c++) begin
            check("hold_fu_valid", 64'(fu_valid), 64'(1));
            check("hold_fu_tag",   64'(fu_tag),   64'(22));
            check("hold_fu_src_a", 64'(fu_src_a), 64'(32'h102));
            check("hold_fu_src_b", 64'(fu_src_b), 64'(32'h302));
            tick();
        end
        fu_rdy = 1'b1;
        tick();
        check("oldest_ready_first", 64'(fu_tag), 64'(20));
        tick();
        check("next_ready", 64'(fu_tag), 64'(23));
        cdb(6'd17, 32'h301);
        tick();
        cdb_en = 1'b0;
        drain(10);

        // Flush overrides a concurrent dispatch and empties everything.
        fu_rdy = 1'b0;
        drive_disp(OP_BEQ, 32'h400, 32'hF000_0000, 2'b11, 32'd1, 32'd2, 6'd0, 6'd0, 6'd40);
        tick();
        drive_disp(OP_BNE, 32'h404, 32'hF000_0001, 2'b01, 32'd3, 32'd0, 6'd0, 6'd33, 6'd41);
        tick();
        drive_disp(OP_BNE, 32'h408, 32'hF000_0002, 2'b01, 32'd4, 32'd0, 6'd0, 6'd34, 6'd42);
        tick();
        idle_disp();
        check("preflush_fu_valid", 64'(fu_valid), 64'(1));
        check("preflush_fu_tag",   64'(fu_tag),   64'(40));
        flush = 1'b1;
        drive_disp(OP_ADD, 32'h40C, 32'hF000_0003, 2'b11, 32'd8, 32'd9, 6'd0, 6'd0, 6'd43);
        tick();
        flush = 1'b0;
        idle_disp();
        check("flush_fu_valid", 64'(fu_valid),   64'(0));
        check("flush_stall",    64'(disp.stall), 64'(0));
        fu_rdy = 1'b1;
        cdb(6'd33, 32'h77);
        tick();
        cdb(6'd34, 32'h78);
        tick();
        cdb_en = 1'b0;
        tick();
        check("flushed_stay_gone", 64'(fu_valid), 64'(0));

        // Asynchronous reset while three entries and the issue register are live.
        fu_rdy = 1'b0;
        drive_disp(OP_XOR, 32'h500, 32'h1234_5678, 2'b11, 32'hA1, 32'hA2, 6'd0, 6'd0, 6'd50);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive_disp(OP_SLL, 32'h504 + 32'(4 * k), 32'h0, 2'b01, 32'd0, 32'd0, 6'd0, 6'(35 + k), 6'(51 + k));
            tick();
        end
        idle_disp();
        check("prereset_fu_valid", 64'(fu_valid),   64'(1));
        check("prereset_stall",    64'(disp.stall), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check("midreset_fu_valid", 64'(fu_valid),   64'(0));
        check("midreset_stall",    64'(disp.stall), 64'(0));
        check("midreset_fu_tag",   64'(fu_tag),     64'(0));
        check("midreset_fu_src_a", 64'(fu_src_a),   64'(0));
        check("midreset_fu_src_b", 64'(fu_src_b),   64'(0));
        check("midreset_fu_insn",  64'(fu_insn),    64'(0));
        tick();
        rst = 1'b0;
        fu_rdy = 1'b1;
        cdb(6'd35, 32'h99);
        tick();
        cdb_en = 1'b0;
        tick();
        tick();
        check("reset_entries_gone", 64'(fu_valid), 64'(0));

        push(OP_SRL, 32'h600, 32'h0BAD_F00D, 32'hA, 32'hB, 6'd7);
        drive_disp(OP_SRL, 32'h600, 32'h0BAD_F00D, 2'b11, 32'hA, 32'hB, 6'd0, 6'd0, 6'd7);
        tick();
        idle_disp();
        drain(10);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
